// File: rtl/pixel_line_fetch_pkg.sv
// Shared video definitions: logical frame geometry, VRAM address width, fetch FSM states.
// Latency: n/a (types, constants and a pure address helper only).
// Backpressure: n/a.
package pixel_line_fetch_pkg;

  localparam int LOGICAL_WIDTH   = 320;
  localparam int LOGICAL_HEIGHT  = 240;
  localparam int VRAM_ADDR_WIDTH = 17;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    DONE,
    DRAIN
  } fetch_state_t;

  // Byte address of (col, line); wraps naturally at 2^VRAM_ADDR_WIDTH.
  function automatic logic [VRAM_ADDR_WIDTH-1:0] line_addr(
    input logic [VRAM_ADDR_WIDTH-1:0] base,
    input logic [7:0]                 line,
    input logic [8:0]                 col,
    input logic [VRAM_ADDR_WIDTH-1:0] width
  );
    return base + VRAM_ADDR_WIDTH'(line) * width + VRAM_ADDR_WIDTH'(col);
  endfunction

endpackage

// File: rtl/pixel_line_fetch_if.sv
// Bundle between the line fetcher, the video output stage and the VRAM arbiter.
// Latency: n/a (wires only). master = fetcher side, slave = environment side.
// Backpressure: memReq/memAddr hold until memGrant; underrunCount exists only with PIXEL_LINE_FETCH_UNDERRUN_COUNT_EN.
interface pixel_line_fetch_if;
  import pixel_line_fetch_pkg::*;

  logic [8:0]                 xCoord;
  logic [7:0]                 yCoord;
  logic [7:0]                 pixel1;
  logic [7:0]                 pixel2;
  logic                       memReq;
  logic [VRAM_ADDR_WIDTH-1:0] memAddr;
  logic                       memGrant;
  logic [7:0]                 memData;
  logic                       memDataValid;
  logic                       underrun;
`ifdef PIXEL_LINE_FETCH_UNDERRUN_COUNT_EN
  logic [15:0]                underrunCount;

  modport master (
    input  xCoord, yCoord, memGrant, memData, memDataValid,
    output pixel1, pixel2, memReq, memAddr, underrun, underrunCount
  );
  modport slave (
    output xCoord, yCoord, memGrant, memData, memDataValid,
    input  pixel1, pixel2, memReq, memAddr, underrun, underrunCount
  );
`else
  modport master (
    input  xCoord, yCoord, memGrant, memData, memDataValid,
    output pixel1, pixel2, memReq, memAddr, underrun
  );
  modport slave (
    output xCoord, yCoord, memGrant, memData, memDataValid,
    input  pixel1, pixel2, memReq, memAddr, underrun
  );
`endif

endinterface

// File: rtl/line_buffer_bank.sv
// Two-bank scanline store: one write port into the fill bank, two reads (x, x+1) of the display bank.
// Latency: 1 cycle from rd_x_i to pix1_o/pix2_o; out-of-line or invalid-bank reads return 0.
// Backpressure: none; a write and a read of the other bank may happen in the same cycle.
module line_buffer_bank #(
  parameter int LINE_WIDTH = 320
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en_i,
  input  logic       wr_bank_i,
  input  logic [8:0] wr_col_i,
  input  logic [7:0] wr_dat_i,
  input  logic       rd_bank_i,
  input  logic       rd_valid_i,
  input  logic [8:0] rd_x_i,
  output logic [7:0] pix1_o,
  output logic [7:0] pix2_o
);

  logic [7:0] mem_q [2][LINE_WIDTH];
  logic [9:0] x0_ext;
  logic [9:0] x1_ext;
  logic [7:0] pix1_d, pix2_d, pix1_q, pix2_q;

  assign x0_ext = {1'b0, rd_x_i};
  assign x1_ext = x0_ext + 10'd1;

  // Storage write; no reset so the array can map onto RAM.
  always_ff @(posedge clock) begin
    if (wr_en_i) mem_q[wr_bank_i][wr_col_i] <= wr_dat_i;
  end

  // Masked read mux: zero outside the line or when the display bank is not filled.
  always_comb begin
    pix1_d = 8'h00;
    pix2_d = 8'h00;
    if (rd_valid_i && x0_ext < 10'(LINE_WIDTH)) pix1_d = mem_q[rd_bank_i][rd_x_i];
    if (rd_valid_i && x1_ext < 10'(LINE_WIDTH)) pix2_d = mem_q[rd_bank_i][x1_ext[8:0]];
  end

  // Registered pixel outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix1_q <= 8'h00;
      pix2_q <= 8'h00;
    end else begin
      pix1_q <= pix1_d;
      pix2_q <= pix2_d;
    end
  end

  assign pix1_o = pix1_q;
  assign pix2_o = pix2_q;

endmodule

// File: rtl/pixel_line_fetch.sv
// Prefetches the next scanline from VRAM into a double-buffered line store and serves pixel pairs.
// Latency: pixels 1 cycle after xCoord; one VRAM byte outstanding at a time.
// Backpressure: memReq/memAddr held until memGrant. Optional PIXEL_LINE_FETCH_UNDERRUN_COUNT_EN adds underrunCount.
module pixel_line_fetch
  import pixel_line_fetch_pkg::*;
#(
  parameter int                         LINE_WIDTH = LOGICAL_WIDTH,
  parameter int                         LINE_COUNT = LOGICAL_HEIGHT,
  parameter logic [VRAM_ADDR_WIDTH-1:0] BASE_ADDR  = 17'h00000
) (
  input logic                 clock,
  input logic                 reset,
  pixel_line_fetch_if.master  bus
);

  fetch_state_t state_q, state_d;
  logic [8:0]   col_q, col_d;
  logic [7:0]   line_q, line_d;
  logic         display_bank_q, display_bank_d;
  logic [1:0]   bank_valid_q, bank_valid_d;
  logic [7:0]   prev_y_q;
  logic         underrun_q;
  logic         line_change;
  logic         fill_bank;
  logic [7:0]   next_line;
  logic         underrun_evt;
  logic         wr_en;

  assign line_change = (bus.yCoord != prev_y_q);
  assign fill_bank   = ~display_bank_q;
  assign next_line   = (bus.yCoord >= 8'(LINE_COUNT - 1)) ? 8'd0 : bus.yCoord + 8'd1;

  // Fetch FSM next state, bank bookkeeping and line-swap handling.
  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    line_d         = line_q;
    display_bank_d = display_bank_q;
    bank_valid_d   = bank_valid_q;
    underrun_evt   = 1'b0;
    wr_en          = 1'b0;
    if (line_change) begin
      // Swap banks; an unfinished fill becomes an invalid display bank.
      // IDLE only occurs before the first swap, when nothing was being fetched.
      display_bank_d = ~display_bank_q;
      line_d         = next_line;
      col_d          = 9'd0;
      if (state_q != DONE) begin
        bank_valid_d[fill_bank] = 1'b0;
        underrun_evt            = (state_q != IDLE);
      end
      bank_valid_d[display_bank_q] = 1'b0;
      // A granted byte still in flight must be drained before re-requesting.
      if ((state_q == WAIT_DATA || state_q == DRAIN) && !bus.memDataValid) state_d = DRAIN;
      else                                                                   state_d = REQ;
    end else begin
      case (state_q)
        REQ:       if (bus.memGrant) state_d = WAIT_DATA;
        WAIT_DATA: if (bus.memDataValid) begin
          wr_en = 1'b1;
          if (col_q == 9'(LINE_WIDTH - 1)) begin
            state_d                 = DONE;
            bank_valid_d[fill_bank] = 1'b1;
          end else begin
            col_d   = col_q + 9'd1;
            state_d = REQ;
          end
        end
        DRAIN:     if (bus.memDataValid) state_d = REQ;
        default:   ;
      endcase
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      col_q          <= 9'd0;
      line_q         <= 8'd0;
      display_bank_q <= 1'b0;
      bank_valid_q   <= 2'b00;
      prev_y_q       <= 8'hFF;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      line_q         <= line_d;
      display_bank_q <= display_bank_d;
      bank_valid_q   <= bank_valid_d;
      prev_y_q       <= bus.yCoord;
      underrun_q     <= underrun_q | underrun_evt;
    end
  end

  // Request is withdrawn in the swap cycle so no grant is taken for a stale line.
  assign bus.memReq   = (state_q == REQ) && !line_change;
  assign bus.memAddr  = bus.memReq ? line_addr(BASE_ADDR, line_q, col_q, VRAM_ADDR_WIDTH'(LINE_WIDTH))
                                   : '0;
  assign bus.underrun = underrun_q;

`ifdef PIXEL_LINE_FETCH_UNDERRUN_COUNT_EN
  logic [15:0] urun_cnt_q;

  // Saturating underrun event counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                    urun_cnt_q <= 16'h0000;
    else if (underrun_evt && urun_cnt_q != 16'hFFFF) urun_cnt_q <= urun_cnt_q + 16'd1;
  end

  assign bus.underrunCount = urun_cnt_q;
`endif

  line_buffer_bank #(
    .LINE_WIDTH (LINE_WIDTH)
  ) u_line_buffer_bank (
    .clock      (clock),
    .reset      (reset),
    .wr_en_i    (wr_en),
    .wr_bank_i  (fill_bank),
    .wr_col_i   (col_q),
    .wr_dat_i   (bus.memData),
    .rd_bank_i  (display_bank_q),
    .rd_valid_i (bank_valid_q[display_bank_q]),
    .rd_x_i     (bus.xCoord),
    .pix1_o     (bus.pixel1),
    .pix2_o     (bus.pixel2)
  );

endmodule

// File: tb/tb_pixel_line_fetch.sv
// Directed bench for pixel_line_fetch with a single-outstanding VRAM arbiter model.
// VRAM content is addr[7:0] ^ 8'h5A; expected bytes below are hand-computed from that.
// Main stimulus acts at negedge+2, the arbiter at negedge+1.
module tb_pixel_line_fetch;

  logic clock = 1'b0;
  logic reset;

  pixel_line_fetch_if bus ();

  pixel_line_fetch dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int          n_cmp       = 0;
  int          n_err       = 0;
  int          grant_count = 0;
  int          bad_contig  = 0;
  int          grant_delay = 0;
  int          wait_cnt    = 0;
  logic [16:0] first_addr  = '0;
  logic [16:0] last_addr   = '0;
  logic [16:0] pend_addr   = '0;
  bit          data_pending = 1'b0;
  bit          hold_data    = 1'b0;
  bit          force_aa     = 1'b0;

  function automatic logic [7:0] vram(input logic [16:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    #2;
  endtask

  task automatic wait_grants(input string tag, input int n, input int budget);
    int left;
    left = budget;
    while (grant_count < n && left > 0) begin
      tick(1);
      left--;
    end
    check_eq(tag, grant_count, n);
  endtask

  // VRAM arbiter: grants after grant_delay cycles of request, returns data one cycle later.
  initial begin
    bus.memGrant     = 1'b0;
    bus.memDataValid = 1'b0;
    bus.memData      = 8'h00;
    forever begin
      @(negedge clock);
      #1;
      bus.memGrant     = 1'b0;
      bus.memDataValid = 1'b0;
      bus.memData      = 8'h00;
      if (data_pending) begin
        if (!hold_data) begin
          bus.memDataValid = 1'b1;
          bus.memData      = force_aa ? 8'hAA : vram(pend_addr);
          force_aa         = 1'b0;
          data_pending     = 1'b0;
        end
      end else if (bus.memReq) begin
        if (wait_cnt < grant_delay) begin
          wait_cnt++;
        end else begin
          bus.memGrant = 1'b1;
          pend_addr    = bus.memAddr;
          data_pending = 1'b1;
          wait_cnt     = 0;
          if (grant_count == 0) first_addr = bus.memAddr;
          else if (bus.memAddr != last_addr + 17'd1) bad_contig++;
          last_addr = bus.memAddr;
          grant_count++;
        end
      end
    end
  end

  initial begin
    int req_cycles;
    int addr_bad;
    reset      = 1'b1;
    bus.xCoord = 9'd0;
    bus.yCoord = 8'd0;
    tick(2);
    check_eq("rst_memReq",   32'(bus.memReq),   0);
    check_eq("rst_memAddr",  32'(bus.memAddr),  0);
    check_eq("rst_pixel1",   32'(bus.pixel1),   0);
    check_eq("rst_pixel2",   32'(bus.pixel2),   0);
    check_eq("rst_underrun", 32'(bus.underrun), 0);
`ifdef PIXEL_LINE_FETCH_UNDERRUN_COUNT_EN
    check_eq("rst_urun_count", 32'(bus.underrunCount), 0);
`endif

    // Line 1 prefetch right after reset release (y=0 counts as a line change).
    reset = 1'b0;
    wait_grants("fill1_first_grant", 1, 50);
    check_eq("fill1_first_addr", 32'(first_addr), 320);
    bus.xCoord = 9'd5;
    wait_grants("fill1_grants", 320, 2000);
    tick(3);
    check_eq("fill1_contig", bad_contig, 0);
    check_eq("fill1_last_addr", 32'(last_addr), 639);
    check_eq("fill1_done_memReq", 32'(bus.memReq), 0);
    check_eq("preswap_pixel1", 32'(bus.pixel1), 0);

    // Swap to line 1 with a slow arbiter fetching line 2.
    grant_delay = 10;
    grant_count = 0;
    bad_contig  = 0;
    bus.yCoord  = 8'd1;
    req_cycles  = 0;
    addr_bad    = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (bus.memGrant) break;
      if (bus.memReq) begin
        req_cycles++;
        if (bus.memAddr != 17'd640) addr_bad++;
      end
    end
    grant_delay = 0;
    check_eq("hold_req_cycles", req_cycles, 10);
    check_eq("hold_addr_stable", addr_bad, 0);
    check_eq("fill2_first_addr", 32'(first_addr), 640);
    check_eq("line1_pixel1", 32'(bus.pixel1), 32'h1F);
    check_eq("line1_pixel2", 32'(bus.pixel2), 32'h1C);
    check_eq("line1_underrun", 32'(bus.underrun), 0);
    wait_grants("fill2_grants", 320, 2000);
    tick(3);
    check_eq("fill2_contig", bad_contig, 0);

    // Line 2 on display: content and right-edge masking.
    grant_count = 0;
    bus.yCoord  = 8'd2;
    bus.xCoord  = 9'd0;
    tick(2);
    check_eq("line2_x0_pixel1", 32'(bus.pixel1), 32'hDA);
    check_eq("line2_x0_pixel2", 32'(bus.pixel2), 32'hDB);
    bus.xCoord = 9'd319;
    tick(1);
    check_eq("x319_pixel1", 32'(bus.pixel1), 32'hE5);
    check_eq("x319_pixel2", 32'(bus.pixel2), 0);
    bus.xCoord = 9'd320;
    tick(1);
    check_eq("x320_pixel1", 32'(bus.pixel1), 0);
    check_eq("x320_pixel2", 32'(bus.pixel2), 0);
    wait_grants("fill3_grants", 320, 2000);
    tick(3);

    // Last line: prefetch wraps to line 0.
    grant_count = 0;
    bus.yCoord  = 8'd239;
    wait_grants("wrap_first_grant", 1, 50);
    check_eq("wrap_first_addr", 32'(first_addr), 0);
    wait_grants("wrap_grants", 320, 2000);
    tick(3);
    check_eq("wrap_underrun", 32'(bus.underrun), 0);

    // Swap while a granted byte is outstanding.
    hold_data   = 1'b1;
    grant_count = 0;
    bus.yCoord  = 8'd100;
    wait_grants("l101_first_grant", 1, 50);
    check_eq("l101_first_addr", 32'(first_addr), 32320);
    tick(3);
    bus.yCoord = 8'd101;
    bus.xCoord = 9'd5;
    tick(2);
    check_eq("drain_underrun", 32'(bus.underrun), 1);
    check_eq("drain_pixel1", 32'(bus.pixel1), 0);
    check_eq("drain_pixel2", 32'(bus.pixel2), 0);
    check_eq("drain_memReq", 32'(bus.memReq), 0);
    grant_count = 0;
    force_aa    = 1'b1;
    hold_data   = 1'b0;
    wait_grants("l102_first_grant", 1, 50);
    check_eq("l102_first_addr", 32'(first_addr), 32640);
`ifdef PIXEL_LINE_FETCH_UNDERRUN_COUNT_EN
    check_eq("urun_count", 32'(bus.underrunCount), 1);
`endif
    wait_grants("l102_grants", 320, 2000);
    tick(3);
    bus.yCoord = 8'd102;
    bus.xCoord = 9'd0;
    tick(2);
    check_eq("l102_pixel1", 32'(bus.pixel1), 32'hDA);
    check_eq("l102_pixel2", 32'(bus.pixel2), 32'hDB);
    check_eq("sticky_underrun", 32'(bus.underrun), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
